// File: rtl/vga_board_renderer.sv
// Pixel stage after the VGA timing controller: draws a 3x3 game board with marks and a cursor.
// Optional macro GRID_LINES_EN adds 4 px white grid lines on every cell edge.
`timescale 1ns/1ps
module vga_board_renderer #(
   parameter int H_ACT_START = 144,
   parameter int V_ACT_START = 35,
   parameter int H_ACT       = 640,
   parameter int V_ACT       = 480,
   parameter int BOARD_X0    = 80,
   parameter int CELL        = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] h_count,
   input  logic [15:0] v_count,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        frame_tick
);

   localparam logic [15:0] H_LO  = 16'(H_ACT_START);
   localparam logic [15:0] H_HI  = 16'(H_ACT_START + H_ACT);
   localparam logic [15:0] V_LO  = 16'(V_ACT_START);
   localparam logic [15:0] V_HI  = 16'(V_ACT_START + V_ACT);
   localparam logic [9:0]  H_OFF = 10'(H_ACT_START);
   localparam logic [9:0]  V_OFF = 10'(V_ACT_START);
   localparam logic [9:0]  X_LO  = 10'(BOARD_X0);
   localparam logic [9:0]  X_HI  = 10'(BOARD_X0 + 3 * CELL);
   localparam logic [9:0]  C1    = 10'(CELL);
   localparam logic [9:0]  C2    = 10'(2 * CELL);
`ifdef GRID_LINES_EN
   localparam int          LINE_W = 4;
   localparam logic [9:0]  LW     = 10'(LINE_W);
   localparam logic [9:0]  EDGE   = 10'(3 * CELL - LINE_W);
`endif

   localparam logic [1:0]  CELL_EMPTY = 2'b00;
   localparam logic [1:0]  CELL_P1    = 2'b01;
   localparam logic [1:0]  CELL_P2    = 2'b10;

   localparam logic [23:0] RGB_BLACK = 24'h000000;
   localparam logic [23:0] RGB_EMPTY = 24'h202020;
   localparam logic [23:0] RGB_P1    = 24'hFF0000;
   localparam logic [23:0] RGB_P2    = 24'h0000FF;
`ifdef GRID_LINES_EN
   localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
`endif
   localparam logic [7:0]  CURSOR_G  = 8'h80;

   function automatic logic [3:0] cell_index(input logic [1:0] r, input logic [1:0] c);
      return 4'(r) * 4'd3 + 4'(c);
   endfunction

   logic       frame_start;
   logic       s1_active;
   logic       s1_hsync;
   logic       s1_vsync;
   logic       s1_start;
   logic [9:0] s1_x;
   logic [9:0] s1_y;

   assign frame_start = (h_count == 16'd0) && (v_count == 16'd0);

   // Stage 1: active-window decode and conversion to active-area coordinates.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_active <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_start  <= 1'b0;
      end else begin
         s1_active <= (h_count >= H_LO) && (h_count < H_HI) &&
                      (v_count >= V_LO) && (v_count < V_HI);
         s1_x      <= h_count[9:0] - H_OFF;
         s1_y      <= v_count[9:0] - V_OFF;
         s1_hsync  <= hsync_in;
         s1_vsync  <= vsync_in;
         s1_start  <= frame_start;
      end
   end

   logic [1:0] cells [0:8];
   logic [1:0] cur_col;
   logic [1:0] cur_row;
   logic       player;
   logic       pend_up;
   logic       pend_down;
   logic       pend_left;
   logic       pend_right;
   logic       pend_sel;

   logic [9:0] bx;
   logic       in_board;
   logic [1:0] col;
   logic [1:0] row;
   logic [3:0] pix_idx;
   logic       on_cursor;
   logic [23:0] pix_rgb;

   assign bx        = s1_x - X_LO;
   assign in_board  = (s1_x >= X_LO) && (s1_x < X_HI);
   assign col       = (bx < C1) ? 2'd0 : (bx < C2) ? 2'd1 : 2'd2;
   assign row       = (s1_y < C1) ? 2'd0 : (s1_y < C2) ? 2'd1 : 2'd2;
   assign pix_idx   = cell_index(row, col);
   assign on_cursor = (col == cur_col) && (row == cur_row);

`ifdef GRID_LINES_EN
   logic [9:0] lx;
   logic [9:0] ly;
   logic       on_grid;

   assign lx      = bx - ((col == 2'd0) ? 10'd0 : (col == 2'd1) ? C1 : C2);
   assign ly      = s1_y - ((row == 2'd0) ? 10'd0 : (row == 2'd1) ? C1 : C2);
   assign on_grid = (lx < LW) || (ly < LW) || (bx >= EDGE) || (s1_y >= EDGE);
`endif

   // Grid lines win over everything; the cursor only retints the green channel of a cell.
   always_comb begin
      pix_rgb = RGB_BLACK;
      if (s1_active && in_board) begin
         case (cells[pix_idx])
            CELL_P1: pix_rgb = RGB_P1;
            CELL_P2: pix_rgb = RGB_P2;
            default: pix_rgb = RGB_EMPTY;
         endcase
         if (on_cursor) pix_rgb[15:8] = CURSOR_G;
`ifdef GRID_LINES_EN
         if (on_grid) pix_rgb = RGB_WHITE;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         red        <= '0;
         green      <= '0;
         blue       <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         red        <= pix_rgb[23:16];
         green      <= pix_rgb[15:8];
         blue       <= pix_rgb[7:0];
         hsync_out  <= s1_hsync;
         vsync_out  <= s1_vsync;
         frame_tick <= s1_start;
      end
   end

   logic       go_up;
   logic       go_down;
   logic       go_left;
   logic       go_right;
   logic       go_sel;
   logic [1:0] next_col;
   logic [1:0] next_row;
   logic [3:0] sel_idx;
   logic       sel_ok;

   // A pulse landing on the apply cycle itself is merged in so it is not lost.
   assign go_up    = pend_up    | btn_up;
   assign go_down  = pend_down  | btn_down;
   assign go_left  = pend_left  | btn_left;
   assign go_right = pend_right | btn_right;
   assign go_sel   = pend_sel   | btn_sel;

   always_comb begin
      next_row = cur_row;
      next_col = cur_col;
      if (go_up && !go_down && cur_row != 2'd0)
         next_row = cur_row - 2'd1;
      else if (go_down && !go_up && cur_row != 2'd2)
         next_row = cur_row + 2'd1;
      if (go_left && !go_right && cur_col != 2'd0)
         next_col = cur_col - 2'd1;
      else if (go_right && !go_left && cur_col != 2'd2)
         next_col = cur_col + 2'd1;
   end

   assign sel_idx = cell_index(next_row, next_col);
   assign sel_ok  = go_sel && (cells[sel_idx] == CELL_EMPTY);

   // Board state only changes at the top of a frame so a frame never shows two board states.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_up    <= 1'b0;
         pend_down  <= 1'b0;
         pend_left  <= 1'b0;
         pend_right <= 1'b0;
         pend_sel   <= 1'b0;
         cur_col    <= 2'd1;
         cur_row    <= 2'd1;
         player     <= 1'b0;
         for (int i = 0; i < 9; i++) cells[i] <= CELL_EMPTY;
      end else if (frame_start) begin
         pend_up    <= 1'b0;
         pend_down  <= 1'b0;
         pend_left  <= 1'b0;
         pend_right <= 1'b0;
         pend_sel   <= 1'b0;
         cur_col    <= next_col;
         cur_row    <= next_row;
         if (sel_ok) begin
            cells[sel_idx] <= player ? CELL_P2 : CELL_P1;
            player         <= ~player;
         end
      end else begin
         pend_up    <= go_up;
         pend_down  <= go_down;
         pend_left  <= go_left;
         pend_right <= go_right;
         pend_sel   <= go_sel;
      end
   end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: pixel vector table plus board-state sequences, all expectations
// queued when driven and compared two cycles later. Honours GRID_LINES_EN for the table colours.
`timescale 1ns/1ps
module tb_vga_board_renderer;

   localparam logic [4:0] B_NONE  = 5'b00000;
   localparam logic [4:0] B_UP    = 5'b10000;
   localparam logic [4:0] B_DOWN  = 5'b01000;
   localparam logic [4:0] B_LEFT  = 5'b00100;
   localparam logic [4:0] B_RIGHT = 5'b00010;
   localparam logic [4:0] B_SEL   = 5'b00001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] h_count = '0;
   logic [15:0] v_count = '0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_sel = 1'b0;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        hsync_out;
   logic        vsync_out;
   logic        frame_tick;

   typedef struct packed {
      logic        chk;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        tick;
   } exp_t;

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
      logic [23:0] rgb_grid;
   } vec_t;

   exp_t  sb_q[$];
   string name_q[$];
   vec_t  vecs[$];
   int    checks = 0;
   int    errors = 0;
   exp_t  cur_exp;
   string cur_name;

   vga_board_renderer dut (
      .clk       (clk),
      .rst       (rst),
      .h_count   (h_count),
      .v_count   (v_count),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_sel   (btn_sel),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check_output(input exp_t e, input string nm);
      logic [26:0] act;
      logic [26:0] req;
      act = {red, green, blue, hsync_out, vsync_out, frame_tick};
      req = {e.rgb, e.hs, e.vs, e.tick};
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got rgb=%06h hs=%b vs=%b tick=%b, want rgb=%06h hs=%b vs=%b tick=%b",
                  nm, act[26:3], act[2], act[1], act[0], e.rgb, e.hs, e.vs, e.tick);
      end
   endtask

   // Each driven cycle pushes one entry; output for it is visible two posedges later.
   always @(posedge clk) begin
      #2;
      if (sb_q.size() >= 2) begin
         cur_exp  = sb_q.pop_front();
         cur_name = name_q.pop_front();
         if (cur_exp.chk) check_output(cur_exp, cur_name);
      end
   end

   task automatic apply_stimulus(input logic [15:0] h, input logic [15:0] v,
                                 input logic hs, input logic vs, input logic [4:0] b,
                                 input logic chk, input logic [23:0] rgb, input string nm);
      exp_t e;
      @(negedge clk);
      h_count  = h;
      v_count  = v;
      hsync_in = hs;
      vsync_in = vs;
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
      e.chk  = chk;
      e.rgb  = rgb;
      e.hs   = hs;
      e.vs   = vs;
      e.tick = (h == 16'd0) && (v == 16'd0);
      sb_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(16'd10, 16'd10, 1'b0, 1'b0, B_NONE, 1'b0, 24'h0, "idle");
   endtask

   task automatic press(input logic [4:0] b);
      apply_stimulus(16'd10, 16'd10, 1'b0, 1'b0, b, 1'b0, 24'h0, "press");
   endtask

   task automatic frame_start(input logic [4:0] b, input string nm);
      apply_stimulus(16'd0, 16'd0, 1'b1, 1'b1, b, 1'b1, 24'h0, nm);
   endtask

   // Centre pixel of cell (c, r), well clear of any grid line.
   task automatic probe(input int c, input int r, input logic [23:0] rgb, input string nm);
      apply_stimulus(16'(304 + 160 * c), 16'(115 + 160 * r), 1'b0, 1'b1, B_NONE, 1'b1, rgb, nm);
   endtask

   task automatic reset_check(input string nm);
      @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      name_q.delete();
      @(posedge clk);
      #2;
      check_output(exp_t'(0), nm);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs.push_back(vec_t'{16'd464, 16'd275, 1'b1, 1'b0, 24'h208020, 24'h208020});
      vecs.push_back(vec_t'{16'd304, 16'd115, 1'b0, 1'b1, 24'h202020, 24'h202020});
      vecs.push_back(vec_t'{16'd144, 16'd35,  1'b1, 1'b1, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd10,  16'd100, 1'b0, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd223, 16'd35,  1'b1, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd224, 16'd35,  1'b0, 1'b1, 24'h202020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd703, 16'd275, 1'b0, 1'b0, 24'h202020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd704, 16'd275, 1'b1, 1'b1, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd783, 16'd100, 1'b0, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd784, 16'd100, 1'b1, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd464, 16'd514, 1'b0, 1'b1, 24'h202020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd464, 16'd515, 1'b0, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd464, 16'd34,  1'b1, 1'b0, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd383, 16'd194, 1'b0, 1'b0, 24'h202020, 24'h202020});
      vecs.push_back(vec_t'{16'd384, 16'd195, 1'b1, 1'b1, 24'h208020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd543, 16'd354, 1'b0, 1'b1, 24'h208020, 24'h208020});
      vecs.push_back(vec_t'{16'd544, 16'd354, 1'b1, 1'b0, 24'h202020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd384, 16'd85,  1'b0, 1'b0, 24'h202020, 24'hFFFFFF});
      vecs.push_back(vec_t'{16'd0,   16'd0,   1'b1, 1'b1, 24'h000000, 24'h000000});
      vecs.push_back(vec_t'{16'd799, 16'd524, 1'b1, 1'b1, 24'h000000, 24'h000000});

      $display("[TB] reset and pixel table");
      reset_check("reset_state");
      for (int i = 0; i < vecs.size(); i++) begin
`ifdef GRID_LINES_EN
         apply_stimulus(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, B_NONE, 1'b1,
                        vecs[i].rgb_grid, $sformatf("vec%0d", i));
`else
         apply_stimulus(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, B_NONE, 1'b1,
                        vecs[i].rgb, $sformatf("vec%0d", i));
`endif
      end

      $display("[TB] cursor movement");
      press(B_RIGHT);
      idle(2);
      press(B_DOWN);
      probe(1, 1, 24'h208020, "hold_old_cursor");
      probe(2, 2, 24'h202020, "hold_new_cell");
      frame_start(B_NONE, "fs_move");
      probe(1, 1, 24'h202020, "moved_from");
      probe(2, 2, 24'h208020, "moved_to");
      press(B_RIGHT);
      press(B_RIGHT);
      frame_start(B_NONE, "fs_sat_r");
      probe(2, 2, 24'h208020, "sat_right");
      press(B_DOWN);
      frame_start(B_NONE, "fs_sat_d");
      probe(2, 2, 24'h208020, "sat_down");

      $display("[TB] marks and player");
      press(B_LEFT);
      press(B_UP);
      frame_start(B_NONE, "fs_center");
      probe(1, 1, 24'h208020, "back_center");
      press(B_SEL);
      frame_start(B_NONE, "fs_sel1");
      probe(1, 1, 24'hFF8000, "sel_p1");
      press(B_SEL);
      frame_start(B_NONE, "fs_sel2");
      probe(1, 1, 24'hFF8000, "sel_ignored");
      press(B_RIGHT | B_SEL);
      frame_start(B_NONE, "fs_sel3");
      probe(2, 1, 24'h0080FF, "sel_p2_postmove");
      probe(1, 1, 24'hFF0000, "p1_no_cursor");

      $display("[TB] cancelling pairs and apply-cycle pulse");
      press(B_UP);
      press(B_DOWN);
      frame_start(B_NONE, "fs_ud");
      probe(2, 1, 24'h0080FF, "updown_cancel");
      press(B_LEFT | B_RIGHT);
      frame_start(B_NONE, "fs_lr");
      probe(2, 1, 24'h0080FF, "lr_cancel");
      frame_start(B_LEFT, "fs_left_pulse");
      probe(1, 1, 24'hFF8000, "apply_cycle_left");
      probe(2, 1, 24'h0000FF, "p2_mark");
      press(B_UP | B_LEFT | B_SEL);
      frame_start(B_NONE, "fs_sel4");
      probe(0, 0, 24'hFF8000, "p1_again");

      $display("[TB] reset during active video");
      press(B_RIGHT);
      apply_stimulus(16'd464, 16'd275, 1'b1, 1'b1, B_NONE, 1'b1, 24'hFF0000, "pre_reset");
      apply_stimulus(16'd464, 16'd275, 1'b1, 1'b1, B_NONE, 1'b1, 24'hFF0000, "pre_reset_b");
      apply_stimulus(16'd464, 16'd275, 1'b1, 1'b1, B_NONE, 1'b1, 24'hFF0000, "pre_reset_c");
      reset_check("reset_mid");
      frame_start(B_NONE, "fs_post_rst");
      probe(1, 1, 24'h208020, "post_rst_center");
      probe(0, 0, 24'h202020, "post_rst_00");
      press(B_SEL);
      frame_start(B_NONE, "fs_post_sel");
      probe(1, 1, 24'hFF8000, "post_rst_p1");
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
